// File: rtl/register_fifo.sv
// Single-clock show-ahead FIFO of DEPTH x WIDTH words with occupancy count,
// full/empty/almost-full flags and sticky overflow/underflow error flags.
module register_fifo #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       write_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       read_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_acc;
    logic             wr_acc;

    // A write into a full FIFO is still accepted if a pop frees a slot this cycle.
    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || rd_acc);

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == CW'(0));
    assign almost_full = (count >= CW'(AF_LEVEL));
    assign data_out    = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately not reset; contents behind empty are don't-care.
    always_ff @(posedge clk) begin
        if (!clr && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CW'(1);
            end
            if (write_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_fifo.sv
// Directed self-checking bench for register_fifo (WIDTH=5, DEPTH=8, AF_LEVEL=6).
module tb_register_fifo;

    localparam int unsigned WIDTH    = 5;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned AF_LEVEL = 6;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             write_en;
    logic [WIDTH-1:0] data_in;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    register_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .write_en   (write_en),
        .data_in    (data_in),
        .read_en    (read_en),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned v);
        write_en = 1'b1;
        data_in  = WIDTH'(v);
        step();
        write_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int unsigned v);
        chk(tag, 32'(data_out), v);
        read_en = 1'b1;
        step();
        read_en = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_dout"}, 32'(data_out), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        clr      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        rst      = 1'b1;
        #2 rst   = 1'b0;
        #1;
        chk_cleared("async_rst");
        step();
        rst = 1'b1;
        step();
        chk_cleared("idle");

        // Fill 1..8: almost_full from the 6th push, full on the 8th, head stays 1.
        for (int i = 1; i <= 8; i++) begin
            push(i);
            chk("fill_count", 32'(count), i);
            chk("fill_af", 32'(almost_full), (i >= 6) ? 1 : 0);
            chk("fill_full", 32'(full), (i == 8) ? 1 : 0);
            chk("fill_dout", 32'(data_out), 1);
        end

        push(31);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);

        for (int i = 1; i <= 8; i++) begin
            pop_chk("drain_dout", i);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_dout0", 32'(data_out), 0);

        // Read while empty together with a write.
        write_en = 1'b1;
        read_en  = 1'b1;
        data_in  = 5'd17;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_count", 32'(count), 1);
        chk("unf_dout", 32'(data_out), 17);
        chk("unf_ovf_sticky", 32'(overflow), 1);
        step();
        chk("unf_sticky", 32'(underflow), 1);
        pop_chk("unf_pop", 17);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_cleared("clr1");

        // Pointer wrap: 4 rounds of push 5 / pop 5, values 0..19.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) push(r * 5 + k);
            chk("wrap_count", 32'(count), 5);
            for (int k = 0; k < 5; k++) pop_chk("wrap_dout", r * 5 + k);
        end
        chk("wrap_empty", 32'(empty), 1);

        for (int i = 20; i < 28; i++) push(i);
        chk("full2", 32'(full), 1);
        write_en = 1'b1;
        read_en  = 1'b1;
        data_in  = 5'd28;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("both_count", 32'(count), 8);
        chk("both_ovf", 32'(overflow), 0);
        chk("both_dout", 32'(data_out), 21);

        // Build count=4, overflow=1, then assert reset between edges.
        push(30);
        chk("mid_ovf", 32'(overflow), 1);
        for (int i = 21; i < 25; i++) pop_chk("mid_pop", i);
        chk("mid_count", 32'(count), 4);
        #2 rst = 1'b0;
        #1;
        chk_cleared("mid_rst");
        #1 rst = 1'b1;
        step();
        chk_cleared("post_rst");

        for (int i = 1; i <= 8; i++) push(i + 8);
        push(3);
        for (int i = 1; i <= 4; i++) pop_chk("clr_pop", i + 8);
        chk("clr_pre_count", 32'(count), 4);
        chk("clr_pre_ovf", 32'(overflow), 1);
        clr      = 1'b1;
        write_en = 1'b1;
        data_in  = 5'd9;
        #1;
        chk("clr_not_yet", 32'(count), 4);
        step();
        clr      = 1'b0;
        write_en = 1'b0;
        chk_cleared("clr2");
        step();
        chk("clr_nowrite_count", 32'(count), 0);
        push(5);
        chk("clr_after_dout", 32'(data_out), 5);
        chk("clr_after_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
